// File: rtl/pattern_gen_multi.sv
// Multi-pattern VGA test-pattern generator.
// Stage 1 tracks col/row from the incoming syncs, stage 2 registers colour,
// so syncs and colour both leave two cycles after they arrive.
module pattern_gen_multi #(
  parameter int VIDEO_WIDTH = 3,
  parameter int TOTAL_COLS  = 800,
  parameter int TOTAL_ROWS  = 525,
  parameter int ACTIVE_COLS = 640,
  parameter int ACTIVE_ROWS = 480,
  parameter int COUNT_WIDTH = 10,
  parameter int BAR_W       = 80,
  parameter int CHECK_LOG2  = 5,
  parameter int GRID_LOG2   = 6,
  parameter int GRAD_SHIFT  = 6,
  parameter int MOVE_W      = 16,
  parameter int MOVE_STEP   = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   hsync,
  input  logic                   vsync,
  input  logic [2:0]             pattern,
  output logic                   ohsync,
  output logic                   ovsync,
  output logic [VIDEO_WIDTH-1:0] redv,
  output logic [VIDEO_WIDTH-1:0] grnv,
  output logic [VIDEO_WIDTH-1:0] bluv,
  output logic                   locked
);

  localparam int CW = COUNT_WIDTH;
  localparam int XW = COUNT_WIDTH + 1;  // headroom for x + step / x + width

  // stage 1 state: coordinates of the pixel sampled at the last edge
  logic          r_hs1, r_vs1, r_locked;
  logic [CW-1:0] r_col, r_row, r_barcnt, r_x;
  logic [2:0]    r_bar, r_pat;

  logic          w_fs, w_line_start;
  logic [CW-1:0] w_col_n, w_row_n, w_barcnt_n, w_x_n;
  logic [2:0]    w_bar_n;
  logic [XW-1:0] w_x_sum;

  assign w_fs         = vsync & ~r_vs1;
  assign w_line_start = w_fs | (r_col == CW'(TOTAL_COLS - 1));

  // next col/row and incremental bar index; a frame start overrides everything
  always_comb begin
    w_col_n    = r_col + 1'b1;
    w_row_n    = r_row;
    w_bar_n    = r_bar;
    w_barcnt_n = r_barcnt + 1'b1;
    if (r_col == CW'(TOTAL_COLS - 1)) begin
      w_col_n = '0;
      w_row_n = (r_row == CW'(TOTAL_ROWS - 1)) ? '0 : r_row + 1'b1;
    end
    if (w_line_start) begin
      w_bar_n    = '0;
      w_barcnt_n = '0;
    end else if (r_barcnt == CW'(BAR_W - 1)) begin
      w_barcnt_n = '0;
      w_bar_n    = (r_bar == 3'd7) ? 3'd7 : r_bar + 3'd1;
    end
    if (w_fs) begin
      w_col_n = '0;
      w_row_n = '0;
    end
  end

  // moving-bar position advances once per frame, wrapping inside the active width
  always_comb begin
    w_x_sum = XW'(r_x) + XW'(MOVE_STEP);
    w_x_n   = r_x;
    if (w_fs && pattern == 3'd7)
      w_x_n = (w_x_sum >= XW'(ACTIVE_COLS)) ? CW'(w_x_sum - XW'(ACTIVE_COLS)) : CW'(w_x_sum);
  end

  // stage 1 registers: sync delay, counters, per-frame latches
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hs1    <= 1'b0;
      r_vs1    <= 1'b0;
      r_locked <= 1'b0;
      r_col    <= '0;
      r_row    <= '0;
      r_barcnt <= '0;
      r_bar    <= '0;
      r_x      <= '0;
      r_pat    <= '0;
    end else begin
      r_hs1    <= hsync;
      r_vs1    <= vsync;
      r_locked <= r_locked | w_fs;
      r_col    <= w_col_n;
      r_row    <= w_row_n;
      r_barcnt <= w_barcnt_n;
      r_bar    <= w_bar_n;
      r_x      <= w_x_n;
      if (w_fs) r_pat <= pattern;
    end
  end

  logic                   w_active, w_on;
  logic [XW-1:0]          w_colx, w_xx;
  logic [VIDEO_WIDTH-1:0] w_r, w_g, w_b, w_grad;

  assign w_active = r_locked && (r_col < CW'(ACTIVE_COLS)) && (r_row < CW'(ACTIVE_ROWS));
  assign w_colx   = XW'(r_col);
  assign w_xx     = XW'(r_x);
  assign w_grad   = VIDEO_WIDTH'(r_col >> GRAD_SHIFT);

  // pattern decode for the stage 1 pixel
  always_comb begin
    w_on = 1'b0;
    w_r  = '0;
    w_g  = '0;
    w_b  = '0;
    case (r_pat)
      3'd1: w_on = 1'b1;
      3'd3: w_on = ~(r_col[CHECK_LOG2] ^ r_row[CHECK_LOG2]);
      3'd4: w_on = (r_col[GRID_LOG2-1:0] == '0) || (r_row[GRID_LOG2-1:0] == '0);
      3'd5: w_on = (r_col == '0) || (r_col == CW'(ACTIVE_COLS - 1)) ||
                   (r_row == '0) || (r_row == CW'(ACTIVE_ROWS - 1));
      3'd7: w_on = (w_colx >= w_xx) && (w_colx < w_xx + XW'(MOVE_W));
      default: w_on = 1'b0;
    endcase
    if (r_pat == 3'd2) begin
      w_r = {VIDEO_WIDTH{~r_bar[1]}};
      w_g = {VIDEO_WIDTH{~r_bar[2]}};
      w_b = {VIDEO_WIDTH{~r_bar[0]}};
    end else if (r_pat == 3'd6) begin
      w_r = w_grad;
      w_g = w_grad;
      w_b = w_grad;
    end else begin
      w_r = {VIDEO_WIDTH{w_on}};
      w_g = {VIDEO_WIDTH{w_on}};
      w_b = {VIDEO_WIDTH{w_on}};
    end
    if (!w_active) begin
      w_r = '0;
      w_g = '0;
      w_b = '0;
    end
  end

  // stage 2 registers: aligned outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ohsync <= 1'b0;
      ovsync <= 1'b0;
      redv   <= '0;
      grnv   <= '0;
      bluv   <= '0;
      locked <= 1'b0;
    end else begin
      ohsync <= r_hs1;
      ovsync <= r_vs1;
      redv   <= w_r;
      grnv   <= w_g;
      bluv   <= w_b;
      locked <= r_locked;
    end
  end

endmodule

// File: tb/tb_pattern_gen_multi.sv
// Directed bench for pattern_gen_multi; frame starts are forced with vsync
// rises whenever convenient, so only the rows under test are scanned.
module tb_pattern_gen_multi;

  logic       clock = 1'b0;
  logic       reset, hsync, vsync;
  logic [2:0] pattern;
  logic       ohsync, ovsync, locked;
  logic [2:0] redv, grnv, bluv;

  int checks = 0;
  int errors = 0;
  int ss_col = 0;  // coordinates of the pixel sampled at the latest edge
  int ss_row = 0;

  pattern_gen_multi dut (
    .clock(clock), .reset(reset), .hsync(hsync), .vsync(vsync), .pattern(pattern),
    .ohsync(ohsync), .ovsync(ovsync), .redv(redv), .grnv(grnv), .bluv(bluv),
    .locked(locked)
  );

  always #5 clock = ~clock;

  task automatic tick_adv();
    @(posedge clock);
    #1;
    ss_col++;
    if (ss_col == 800) begin
      ss_col = 0;
      ss_row = (ss_row == 524) ? 0 : ss_row + 1;
    end
  endtask

  task automatic frame_start(input logic [2:0] p);
    pattern = p;
    vsync   = 1'b1;
    @(posedge clock);
    #1;
    vsync  = 1'b0;
    ss_col = 0;
    ss_row = 0;
  endtask

  // advance until pixel (c,r) has been sampled, then one more edge so outputs show it
  task automatic show(input int c, input int r);
    int n = 0;
    while (!(ss_col == c && ss_row == r) && n < 450000) begin
      tick_adv();
      n++;
    end
    if (n >= 450000) begin
      checks++;
      errors++;
      $display("FAIL show_timeout col %0d row %0d", c, r);
    end
    tick_adv();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    frame_start(3'd1);
    show(40, 0);
    hsync = 1'b1;
    tick_adv();
    tick_adv();
    checks++;
    if ({ohsync, locked, redv, grnv, bluv} !== 11'b11_111111111) begin
      errors++;
      $display("FAIL pre_reset got %b want %b", {ohsync, locked, redv, grnv, bluv}, 11'b11_111111111);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({ohsync, ovsync, locked, redv, grnv, bluv} !== 12'd0) begin
      errors++;
      $display("FAIL reset_async got %b want 0", {ohsync, ovsync, locked, redv, grnv, bluv});
    end
    repeat (3) tick_adv();
    checks++;
    if ({ohsync, ovsync, locked, redv, grnv, bluv} !== 12'd0) begin
      errors++;
      $display("FAIL reset_held got %b want 0", {ohsync, ovsync, locked, redv, grnv, bluv});
    end
    reset = 1'b0;
    hsync = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick_adv();
      checks++;
      if ({locked, redv, grnv, bluv} !== 10'd0) begin
        errors++;
        $display("FAIL unlocked_dark cyc %0d got %b want 0", i, {locked, redv, grnv, bluv});
      end
    end
    frame_start(3'd1);
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL lock_early got %b want 0", locked);
    end
    tick_adv();
    checks++;
    if ({locked, redv, grnv, bluv} !== 10'b1_111111111) begin
      errors++;
      $display("FAIL lock_set got %b want %b", {locked, redv, grnv, bluv}, 10'b1_111111111);
    end
  endtask

  task automatic test_latency();
    tick_adv();
    tick_adv();
    checks++;
    if (ovsync !== 1'b0) begin
      errors++;
      $display("FAIL ovsync_idle got %b want 0", ovsync);
    end
    frame_start(3'd1);
    checks++;
    if (ovsync !== 1'b0) begin
      errors++;
      $display("FAIL ovsync_t1 got %b want 0", ovsync);
    end
    tick_adv();
    checks++;
    if ({ovsync, redv, grnv, bluv} !== 10'b1_111111111) begin
      errors++;
      $display("FAIL ovsync_t2 got %b want %b", {ovsync, redv, grnv, bluv}, 10'b1_111111111);
    end
    hsync = 1'b1;
    tick_adv();
    hsync = 1'b0;
    checks++;
    if ({ovsync, ohsync} !== 2'b00) begin
      errors++;
      $display("FAIL sync_t1 got %b want 00", {ovsync, ohsync});
    end
    tick_adv();
    checks++;
    if (ohsync !== 1'b1) begin
      errors++;
      $display("FAIL ohsync_t2 got %b want 1", ohsync);
    end
    tick_adv();
    checks++;
    if (ohsync !== 1'b0) begin
      errors++;
      $display("FAIL ohsync_t3 got %b want 0", ohsync);
    end
    show(640, 0);
    checks++;
    if ({redv, grnv, bluv} !== 9'o000) begin
      errors++;
      $display("FAIL blank_c640 got %o want 000", {redv, grnv, bluv});
    end
  endtask

  task automatic test_bars();
    int         cols[6] = '{0, 79, 80, 160, 560, 639};
    logic [8:0] expv[6] = '{9'o777, 9'o777, 9'o770, 9'o077, 9'o000, 9'o000};
    frame_start(3'd2);
    for (int i = 0; i < 6; i++) begin
      show(cols[i], 0);
      checks++;
      if ({redv, grnv, bluv} !== expv[i]) begin
        errors++;
        $display("FAIL bars col %0d got %o want %o", cols[i], {redv, grnv, bluv}, expv[i]);
      end
    end
  endtask

  task automatic test_shapes();
    // pattern, col, row, expected rgb
    logic [2:0] pat[13]  = '{3, 3, 3, 4, 4, 5, 5, 5, 5, 6, 6, 6, 6};
    int         cols[13] = '{31, 32, 32, 64, 65, 0, 1, 639, 640, 0, 64, 448, 512};
    int         rows[13] = '{0, 0, 32, 10, 10, 5, 5, 5, 5, 1, 1, 1, 1};
    logic [8:0] expv[13] = '{9'o777, 9'o000, 9'o777, 9'o777, 9'o000, 9'o777, 9'o000,
                             9'o777, 9'o000, 9'o000, 9'o111, 9'o777, 9'o000};
    for (int i = 0; i < 13; i++) begin
      if (i == 0 || pat[i] != pat[i-1]) begin
        tick_adv();
        frame_start(pat[i]);
      end
      show(cols[i], rows[i]);
      checks++;
      if ({redv, grnv, bluv} !== expv[i]) begin
        errors++;
        $display("FAIL shape pat %0d (%0d,%0d) got %o want %o", pat[i], cols[i], rows[i],
                 {redv, grnv, bluv}, expv[i]);
      end
    end
  endtask

  task automatic test_latch();
    tick_adv();
    frame_start(3'd1);
    show(5, 3);
    pattern = 3'd0;
    show(10, 3);
    checks++;
    if ({redv, grnv, bluv} !== 9'o777) begin
      errors++;
      $display("FAIL latch_hold got %o want 777", {redv, grnv, bluv});
    end
    show(20, 4);
    checks++;
    if ({redv, grnv, bluv} !== 9'o777) begin
      errors++;
      $display("FAIL latch_hold2 got %o want 777", {redv, grnv, bluv});
    end
    frame_start(3'd0);
    show(5, 0);
    checks++;
    if ({redv, grnv, bluv} !== 9'o000) begin
      errors++;
      $display("FAIL latch_next got %o want 000", {redv, grnv, bluv});
    end
  endtask

  task automatic test_moving();
    // frame number, col, expected on (frame 0 = non-7 frame before final 7)
    int   frm[16]  = '{1, 1, 1, 1, 157, 157, 157, 157, 157, 160, 160, 160, 161, 161, 162, 162};
    int   cols[16] = '{3, 4, 19, 20, 0, 627, 628, 639, 640, 0, 15, 16, 3, 4, 7, 8};
    logic expv[16] = '{0, 1, 1, 0, 0, 0, 1, 1, 0, 1, 1, 0, 0, 1, 0, 1};
    int   cur = 0;
    for (int i = 0; i < 16; i++) begin
      while (cur < frm[i]) begin
        tick_adv();
        if (cur == 161) begin
          frame_start(3'd0);  // x must hold across a non-moving frame
          tick_adv();
        end
        frame_start(3'd7);
        cur++;
      end
      show(cols[i], 0);
      checks++;
      if ({redv, grnv, bluv} !== {9{expv[i]}}) begin
        errors++;
        $display("FAIL moving frame %0d col %0d got %o want %o", frm[i], cols[i],
                 {redv, grnv, bluv}, {9{expv[i]}});
      end
    end
  endtask

  initial begin
    reset   = 1'b1;
    hsync   = 1'b0;
    vsync   = 1'b0;
    pattern = 3'd0;
    repeat (3) tick_adv();
    test_reset();
    test_latency();
    test_bars();
    test_shapes();
    test_latch();
    test_moving();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
